// File: rtl/arm_id_exe_stage_reg.sv
// ID/EXE pipeline register: holds on freeze, bubbles on flush or
// hazard, and counts frozen cycles with a saturating counter.
module arm_id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic              S_in,
  input  logic              B_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              WB_en_in,
  input  logic              move_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        SR_in,
  output logic              S_out,
  output logic              B_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              WB_en_out,
  output logic              move_out,
  output logic [3:0]        EXE_CMD_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] Val_Rn_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        Dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        SR_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  freeze_cnt
);

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       move;
    logic [3:0] exe_cmd;
  } ctrl_t;

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic              bubble;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] rn_q;
  logic [DATA_W-1:0] rm_q;
  logic              imm_q;
  logic [11:0]       sh_q;
  logic [23:0]       simm_q;
  logic [3:0]        dest_q;
  logic [3:0]        src1_q;
  logic [3:0]        src2_q;
  logic [3:0]        sr_q;
  logic [CNT_W-1:0]  cnt_q;

  assign bubble = flush | hazard;

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.s         = S_in;
    ctrl_d.b         = B_in;
    ctrl_d.mem_read  = mem_read_in;
    ctrl_d.mem_write = mem_write_in;
    ctrl_d.wb_en     = WB_en_in;
    ctrl_d.move      = move_in;
    ctrl_d.exe_cmd   = EXE_CMD_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= 1'b0;
      sh_q    <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      sr_q    <= '0;
    end else if (!freeze) begin
      // data fields load even for a bubble; only control is squashed
      pc_q   <= PC_in;
      rn_q   <= Val_Rn_in;
      rm_q   <= Val_Rm_in;
      imm_q  <= imm_in;
      sh_q   <= shift_operand_in;
      simm_q <= signed_imm_24_in;
      dest_q <= Dest_in;
      src1_q <= src1_in;
      src2_q <= src2_in;
      sr_q   <= SR_in;
      if (bubble) begin
        ctrl_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        ctrl_q  <= ctrl_d;
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (freeze && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign S_out             = ctrl_q.s;
  assign B_out             = ctrl_q.b;
  assign mem_read_out      = ctrl_q.mem_read;
  assign mem_write_out     = ctrl_q.mem_write;
  assign WB_en_out         = ctrl_q.wb_en;
  assign move_out          = ctrl_q.move;
  assign EXE_CMD_out       = ctrl_q.exe_cmd;
  assign PC_out            = pc_q;
  assign Val_Rn_out        = rn_q;
  assign Val_Rm_out        = rm_q;
  assign imm_out           = imm_q;
  assign shift_operand_out = sh_q;
  assign signed_imm_24_out = simm_q;
  assign Dest_out          = dest_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign SR_out            = sr_q;
  assign valid_out         = valid_q;
  assign freeze_cnt        = cnt_q;

endmodule

// File: doc/arm_id_exe_stage_reg.md
Name: arm_id_exe_stage_reg

Overview:
Pipeline register between the ID stage (decoder/control unit plus register file) and the EXE stage of the 5-stage ARM core with SRAM data memory. It captures the decoded control word, the operands and the status flags each cycle. It holds its contents while the SRAM controller freezes the pipe. It inserts bubbles on data hazards and squashes the in-flight instruction on a taken branch. It also keeps a saturating freeze-cycle counter for performance debug.

Parameters:
- DATA_W, 32, width of PC and operand values.
- CNT_W, 16, width of the freeze-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- freeze  input  1  SRAM busy; hold all state
- flush  input  1  branch taken in EXE; squash this stage
- hazard  input  1  hazard unit detected RAW hazard; load a bubble
- S_in, B_in, mem_read_in, mem_write_in, WB_en_in, move_in  input  1 each  decoded control bits from ID
- EXE_CMD_in  input  4  ALU command from ID
- PC_in  input  DATA_W  PC+4 of the ID instruction
- Val_Rn_in, Val_Rm_in  input  DATA_W  register file read data
- imm_in  input  1  I bit
- shift_operand_in  input  12  shifter operand field
- signed_imm_24_in  input  24  branch offset
- Dest_in, src1_in, src2_in  input  4 each  destination and source register numbers
- SR_in  input  4  current status register {N,Z,C,V}
- S_out, B_out, mem_read_out, mem_write_out, WB_en_out, move_out  output  1 each  registered control bits
- EXE_CMD_out  output  4  registered ALU command
- PC_out, Val_Rn_out, Val_Rm_out  output  DATA_W  registered data
- imm_out  output  1  registered I bit
- shift_operand_out  output  12  registered shifter operand
- signed_imm_24_out  output  24  registered branch offset
- Dest_out, src1_out, src2_out  output  4 each  registered register numbers
- SR_out  output  4  registered status flags
- valid_out  output  1  stage holds a real instruction
- freeze_cnt  output  CNT_W  count of frozen cycles

Behaviour:
- Reset (rst=0, async): every output is 0, including valid_out and freeze_cnt. Release is synchronous to the next clk edge.
- Load priority each rising edge, highest first: freeze, flush, hazard, normal load.
- freeze=1:
  - Every register holds its value, regardless of flush or hazard.
  - A flush asserted during freeze takes effect on the first unfrozen edge, provided the upstream logic still holds flush high then.
- flush=1 (freeze=0):
  - Control bits (S, B, mem_read, mem_write, WB_en, move), EXE_CMD and valid_out go to 0.
  - Data fields load from the inputs normally; their values are don't-care for the squashed slot.
- hazard=1 (freeze=0, flush=0): bubble, with identical effect to flush. The hazard unit freezes PC and IF/ID separately.
- Normal load (freeze=0, flush=0, hazard=0):
  - All fields load from their inputs; valid_out=1.
  - The S bit loads unchanged; CMP/TST arrive with S_in=1.
- Latency: exactly 1 cycle from input to output on a normal load.
- freeze_cnt:
  - Increments by 1 on every rising edge with freeze=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Not cleared by flush; cleared only by reset.
- There is no combinational path from any input to any output.
- Bubble invariant: whenever valid_out=0, mem_read_out, mem_write_out, WB_en_out and B_out are all 0.

Test Plan:
- Reset mid-operation: load an ADD (WB_en=1, EXE_CMD=0010), assert rst=0 between edges -> all outputs 0 immediately, not waiting for clk; valid_out=0.
- Normal load: LDR (mem_read=1, WB_en=1, S=1, EXE_CMD=0010, Val_Rn=32'h100, Dest=4'd3) -> next edge outputs match exactly; valid_out=1.
- Freeze hold: load an STR, then hold freeze=1 for 5 cycles while inputs change -> outputs unchanged for all 5 cycles, freeze_cnt=5; first edge after release loads the new inputs.
- Flush vs freeze: assert flush and freeze together for 2 cycles, then flush alone for 1 cycle -> contents held for 2 cycles, then bubble (WB_en_out=0, valid_out=0, EXE_CMD_out=0).
- Hazard bubble: MOV in ID (move=1, WB_en=1, EXE_CMD=0001) with hazard=1 -> bubble loaded; next cycle with hazard=0 -> MOV loads with valid_out=1.
- Counter saturation: with CNT_W=4, hold freeze for 20 cycles -> freeze_cnt stops at 4'hF and stays there.
